fixed_div_nb: RTL

Multi-cycle signed fixed-point divider. It is the inverse companion to `fixed_mul_nb` and uses the same pulse handshake: `din_valid` in, `dout_valid` out. It computes a truncating signed quotient and remainder over `WIDTH+1` clocks using radix-2 restoring iteration. It sits in the quantisation path of the JPEG encoder, where coefficients are divided by table entries.

---
 rtl/fixed_div_pkg.sv | 21 ++
 rtl/fixed_div_step.sv | 31 +++
 rtl/fixed_div_nb.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fixed_div_pkg.sv
// Shared definitions for the fixed_div_nb signed divider.
//   div_state_t : controller state (IDLE, CALC, FIX)
//   sat_quot    : saturated quotient for a given width and dividend sign,
//                 used when the divisor is zero
package fixed_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } div_state_t;

  // Returns 2^(w-1)-1 for a non-negative dividend and -2^(w-1) otherwise.
  // The result is 64 bits wide; callers size-cast it to their own width.
  function automatic logic signed [63:0] sat_quot(input int unsigned w, input logic neg);
    logic signed [63:0] lim;
    lim = (64'sd1 <<< (w - 1)) - 64'sd1;
    return neg ? ~lim : lim;
  endfunction

endpackage

// File: rtl/fixed_div_step.sv
// One combinational radix-2 restoring division step on magnitudes.
//   rem_in  : partial remainder before the step (always < dmag)
//   dvd_bit : next dividend bit shifted into the remainder
//   dmag    : divisor magnitude
//   rem_out : partial remainder after the step
//   q_bit   : quotient bit produced by the step
module fixed_div_step
  import fixed_div_pkg::*;
#(
  parameter int WIDTH = 26
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] dmag,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem_in < dmag <= 2^(WIDTH-1) keeps shifted below 2^WIDTH, so the MSB of
  // a WIDTH+1 bit trial difference is a reliable borrow indicator.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    trial   = shifted - {1'b0, dmag};
    q_bit   = ~trial[WIDTH];
    rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/fixed_div_nb.sv
// Multi-cycle signed divider with truncating quotient and remainder
// (C semantics). Constant latency of WIDTH+1 clocks per request.
//   clk, nrst   : clock, synchronous active-low reset
//   din1, din2  : dividend, divisor (signed)
//   din_valid   : request pulse, ignored while busy
//   busy        : operation in flight
//   dout_q/r    : quotient / remainder, held until the next result
//   dout_valid  : one-cycle result pulse
//   div_zero    : result produced from a zero divisor
//   ovf         : result produced from most-negative / -1
module fixed_div_nb
  import fixed_div_pkg::*;
#(
  parameter int WIDTH = 26
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic signed [WIDTH-1:0] din1,
  input  logic signed [WIDTH-1:0] din2,
  input  logic                    din_valid,
  output logic                    busy,
  output logic signed [WIDTH-1:0] dout_q,
  output logic signed [WIDTH-1:0] dout_r,
  output logic                    dout_valid,
  output logic                    div_zero,
  output logic                    ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MAX_VAL = ~MIN_VAL;

  div_state_t state, state_next;

  logic [CNT_W-1:0]        cnt;
  logic [WIDTH-1:0]        rem;
  logic [WIDTH-1:0]        dvd;
  logic [WIDTH-1:0]        dmag;
  logic [WIDTH-1:0]        rem_step;
  logic                    q_bit;
  logic                    neg_n;
  logic                    neg_d;
  logic                    is_zero;
  logic                    is_ovf;
  logic signed [WIDTH-1:0] dividend;
  logic signed [WIDTH-1:0] mag1;
  logic signed [WIDTH-1:0] mag2;
  logic signed [WIDTH-1:0] q_fix;
  logic signed [WIDTH-1:0] r_fix;
  logic signed [WIDTH-1:0] q_sat;

  fixed_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .dvd_bit (dvd[WIDTH-1]),
    .dmag    (dmag),
    .rem_out (rem_step),
    .q_bit   (q_bit)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (din_valid) state_next = CALC;
      CALC:    if (cnt == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Negating the most-negative value wraps to the same bit pattern, which
  // read as unsigned is exactly its magnitude 2^(WIDTH-1).
  always_comb begin
    mag1  = din1[WIDTH-1] ? -din1 : din1;
    mag2  = din2[WIDTH-1] ? -din2 : din2;
    q_fix = (neg_n ^ neg_d) ? -$signed(dvd) : $signed(dvd);
    r_fix = neg_n ? -$signed(rem) : $signed(rem);
    q_sat = WIDTH'(sat_quot(WIDTH, neg_n));
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= IDLE;
      cnt        <= '0;
      rem        <= '0;
      dvd        <= '0;
      dmag       <= '0;
      neg_n      <= 1'b0;
      neg_d      <= 1'b0;
      is_zero    <= 1'b0;
      is_ovf     <= 1'b0;
      dividend   <= '0;
      dout_q     <= '0;
      dout_r     <= '0;
      dout_valid <= 1'b0;
      div_zero   <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      state      <= state_next;
      dout_valid <= 1'b0;
      case (state)
        // Accept: capture signs, magnitudes and corner-case flags
        IDLE: begin
          if (din_valid) begin
            neg_n    <= din1[WIDTH-1];
            neg_d    <= din2[WIDTH-1];
            dvd      <= mag1;
            dmag     <= mag2;
            rem      <= '0;
            cnt      <= CNT_W'(WIDTH - 1);
            dividend <= din1;
            is_zero  <= (din2 == '0);
            is_ovf   <= (din1 == MIN_VAL) && (din2 == '1);
          end
        end
        // Iterate: dividend magnitude shifts out, quotient bits shift in
        CALC: begin
          rem <= rem_step;
          dvd <= {dvd[WIDTH-2:0], q_bit};
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        // Finish: apply signs or corner-case overrides and publish
        FIX: begin
          dout_valid <= 1'b1;
          if (is_zero) begin
            dout_q   <= q_sat;
            dout_r   <= dividend;
            div_zero <= 1'b1;
            ovf      <= 1'b0;
          end else if (is_ovf) begin
            dout_q   <= MAX_VAL;
            dout_r   <= '0;
            div_zero <= 1'b0;
            ovf      <= 1'b1;
          end else begin
            dout_q   <= q_fix;
            dout_r   <= r_fix;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
